// File: rtl/dmx_frame_seq.sv
// rtl/dmx_frame_seq.sv - DMX-512 frame sequencer: channel RAM -> dmx_tx handshake
// One frame = flagged start code + NUM_CH channel bytes, spaced by a minimum baud-tick period.
module dmx_frame_seq #(
  parameter int unsigned NUM_CH     = 512,
  parameter logic [7:0]  START_CODE = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        baud_en_i,
  input  logic        enable_i,
  input  logic [19:0] period_i,
  input  logic        buf_sel_i,
  output logic        rd_en_o,
  output logic [9:0]  rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        tx_avail_o,
  output logic [8:0]  tx_data_o,
  input  logic        tx_ack_i,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        active_bank_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_CAPTURE, S_PRESENT, S_GAP
  } state_e;

  localparam logic [8:0] LAST_IDX = 9'(NUM_CH - 1);

  state_e      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [19:0] timer_q, timer_d;
  logic        tx_avail_q, tx_avail_d;
  logic [8:0]  tx_data_q, tx_data_d;
  logic        frame_start_q, frame_start_d;
  logic        active_bank_q, active_bank_d;
  logic        accept;
  logic        begin_frame;

  // An ack only counts while a byte is actually on offer.
  assign accept = tx_avail_q & tx_ack_i;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tx_avail_d    = tx_avail_q;
    tx_data_d     = tx_data_q;
    frame_start_d = 1'b0;
    active_bank_d = active_bank_q;
    begin_frame   = 1'b0;
    frame_done_o  = 1'b0;
    timer_d       = timer_q;
    if (baud_en_i && (timer_q != '1)) begin
      timer_d = timer_q + 20'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin_frame = 1'b1;
      end
      S_START: begin
        if (accept) begin
          tx_avail_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        tx_data_d  = {1'b0, rd_data_i};
        tx_avail_d = 1'b1;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (accept) begin
          tx_avail_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            frame_done_o = 1'b1;
            state_d      = S_GAP;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (timer_q >= period_i) begin
          begin_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering START: bank and timer are captured here so a frame never mixes banks.
    if (begin_frame) begin
      state_d       = S_START;
      active_bank_d = buf_sel_i;
      idx_d         = '0;
      timer_d       = '0;
      tx_data_d     = {1'b1, START_CODE};
      tx_avail_d    = 1'b1;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      tx_avail_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_start_q <= 1'b0;
      active_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      tx_avail_q    <= tx_avail_d;
      tx_data_q     <= tx_data_d;
      frame_start_q <= frame_start_d;
      active_bank_q <= active_bank_d;
    end
  end

  assign rd_en_o       = (state_q == S_FETCH);
  assign rd_addr_o     = {active_bank_q, idx_q};
  assign tx_avail_o    = tx_avail_q;
  assign tx_data_o     = tx_data_q;
  assign frame_start_o = frame_start_q;
  assign active_bank_o = active_bank_q;
  assign busy_o        = (state_q == S_START) || (state_q == S_FETCH) ||
                         (state_q == S_CAPTURE) || (state_q == S_PRESENT);

endmodule

// File: tb/tb_dmx_frame_seq.sv
// tb/tb_dmx_frame_seq.sv - self-checking bench for dmx_frame_seq
// Frame-level model: expected byte stream, bank and busy window derived from accepted bytes.
module tb_dmx_frame_seq;

  localparam int NCH = 4;
  localparam logic [7:0] SC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n, baud_en, enable, buf_sel, tx_ack;
  logic [19:0] period;
  logic        rd_en, tx_avail, frame_start, frame_done, busy, active_bank;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [8:0]  tx_data;

  dmx_frame_seq #(.NUM_CH(NCH), .START_CODE(SC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .enable_i(enable),
    .period_i(period), .buf_sel_i(buf_sel), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .tx_avail_o(tx_avail), .tx_data_o(tx_data), .tx_ack_i(tx_ack),
    .frame_start_o(frame_start), .frame_done_o(frame_done), .busy_o(busy),
    .active_bank_o(active_bank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  logic [7:0] ram [0:7];
  initial begin
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    ram[4] = 8'hAA; ram[5] = 8'hBB; ram[6] = 8'hCC; ram[7] = 8'hDD;
  end

  // Synchronous channel RAM, one cycle read latency.
  initial begin
    rd_data = '0;
    forever begin
      @(posedge clk);
      if (rd_en) rd_data <= ram[{rd_addr[9], rd_addr[1:0]}];
    end
  end

  initial begin
    int bcnt = 0;
    baud_en = 1'b0;
    forever begin
      @(negedge clk);
      baud_en = (bcnt % 4 == 0);
      bcnt++;
    end
  end

  // Model state and ack driver.
  int         ack_delay = 0;
  bit         spur = 0;
  int         wait_cnt = 0;
  int         pos = 0;
  logic       exp_bank = 1'b0;
  bit         in_frame = 0;
  int         rd_cnt = 0;
  int         fs_count = 0;
  int         fd_count = 0;
  longint     cyc = 0;
  longint     fs_cyc [$];
  logic [8:0] acc_log [$];
  bit         prev_avail = 0, prev_acc = 0, acc;
  logic [8:0] prev_data = '0, expv;

  initial begin
    tx_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_ack = 1'b0;
      if (!rst_n) begin
        pos = 0; in_frame = 0; prev_avail = 0; prev_acc = 0; rd_cnt = 0; wait_cnt = 0;
        continue;
      end
      if (prev_avail && !prev_acc) begin
        chk("avail_hold", tx_avail, 1);
        chk("data_hold", tx_data, prev_data);
      end
      if (frame_start) begin
        chk("fs_avail", tx_avail, 1);
        chk("fs_data", tx_data, {1'b1, SC});
        chk("fs_pos", pos, 0);
        in_frame = 1; exp_bank = buf_sel; rd_cnt = 0;
        fs_count++; fs_cyc.push_back(cyc);
      end
      if (rd_en) begin
        rd_cnt++;
        chk("rd_bank", rd_addr[9], exp_bank);
        chk("rd_idx", rd_addr[8:0], pos - 1);
      end
      acc = 0;
      if (spur && !tx_avail) begin
        tx_ack = 1'b1;
      end else if (tx_avail) begin
        if (wait_cnt >= ack_delay) begin
          tx_ack = 1'b1; acc = 1; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      #1;
      chk("busy", busy, in_frame);
      if (in_frame) chk("active_bank", active_bank, exp_bank);
      chk("frame_done", frame_done, acc && (pos == NCH));
      if (acc) begin
        expv = (pos == 0) ? {1'b1, SC} : {1'b0, ram[exp_bank * 4 + pos - 1]};
        chk("accept", tx_data, expv);
        acc_log.push_back(tx_data);
        pos++;
        if (pos == NCH + 1) begin
          chk("rd_count", rd_cnt, NCH);
          pos = 0; in_frame = 0; fd_count++;
        end
      end
      prev_avail = tx_avail; prev_acc = acc; prev_data = tx_data;
    end
  end

  initial begin
    int mark, f0, d0, a0;
    longint iv;
    rst_n = 1'b0; enable = 1'b0; buf_sel = 1'b0; period = '0;
    #23;
    chk("rst_avail", tx_avail, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    step(); rst_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", busy, 0);
    chk("idle_fs_count", fs_count, 0);

    // Basic frames
    enable = 1'b1;
    step();
    chk("first_fs", frame_start, 1);
    chk("first_data", tx_data, 9'h100);
    for (int i = 0; i < 300 && fd_count < 3; i++) step();
    chk("to_basic", fd_count >= 3, 1);
    chk("log0", acc_log[0], 9'h100);
    chk("log1", acc_log[1], 9'h011);
    chk("log2", acc_log[2], 9'h022);
    chk("log3", acc_log[3], 9'h033);
    chk("log4", acc_log[4], 9'h044);
    chk("log5", acc_log[5], 9'h100);

    // Slow ack
    ack_delay = 200;
    d0 = fd_count;
    for (int i = 0; i < 3000 && fd_count == d0; i++) step();
    a0 = acc_log.size();
    for (int i = 0; i < 3000 && fd_count < d0 + 2; i++) step();
    chk("to_slow", fd_count >= d0 + 2, 1);
    chk("slow_accepts", acc_log.size() - a0, NCH + 1);

    // Spurious acks while no byte is offered
    ack_delay = 3; spur = 1;
    d0 = fd_count;
    for (int i = 0; i < 500 && fd_count < d0 + 2; i++) step();
    chk("to_spur", fd_count >= d0 + 2, 1);
    spur = 0; ack_delay = 0;

    // Bank switch during channel 2
    for (int i = 0; i < 200 && pos != 3; i++) step();
    chk("to_sw", pos, 3);
    buf_sel = 1'b1;
    mark = acc_log.size();
    d0 = fd_count;
    for (int i = 0; i < 300 && fd_count < d0 + 2; i++) step();
    chk("to_sw_done", fd_count >= d0 + 2, 1);
    chk("sw_old2", acc_log[mark], 9'h033);
    chk("sw_old3", acc_log[mark + 1], 9'h044);
    chk("sw_sc", acc_log[mark + 2], 9'h100);
    chk("sw_new0", acc_log[mark + 3], 9'h0AA);
    chk("sw_new3", acc_log[mark + 6], 9'h0DD);
    chk("sw_bank", active_bank, 1);

    // Enable off at channel 1
    for (int i = 0; i < 200 && pos != 2; i++) step();
    chk("to_en", pos, 2);
    enable = 1'b0;
    f0 = fs_count; d0 = fd_count; mark = acc_log.size();
    for (int i = 0; i < 200 && fd_count == d0; i++) step();
    step(); step();
    chk("off_rest", acc_log.size() - mark, 3);
    chk("off_ch3", acc_log[mark + 2], 9'h0DD);
    chk("off_busy", busy, 0);
    repeat (50) step();
    chk("off_no_fs", fs_count, f0);
    enable = 1'b1;
    step();
    chk("reen_fs", frame_start, 1);

    // Minimum period
    period = 20'd5000;
    f0 = fs_count;
    for (int i = 0; i < 70000 && fs_count < f0 + 3; i++) step();
    chk("to_period", fs_count >= f0 + 3, 1);
    iv = fs_cyc[fs_cyc.size() - 1] - fs_cyc[fs_cyc.size() - 2];
    checks++;
    if (iv < 19999 || iv > 20001) begin
      errors++;
      $display("FAIL period_interval actual=%0d required=20000+-1", iv);
    end
    period = '0;

    // Reset mid-frame
    for (int i = 0; i < 200 && !(tx_avail && pos == 2); i++) step();
    chk("to_rst", tx_avail && pos == 2, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_avail", tx_avail, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bank", active_bank, 0);
    repeat (3) step();
    mark = acc_log.size();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && acc_log.size() == mark; i++) step();
    chk("to_post_rst", acc_log.size() > mark, 1);
    chk("post_rst_first", acc_log[mark], 9'h100);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmx_frame_seq.md
# dmx_frame_seq

Frame sequencer that continuously refreshes a DMX-512 universe through the `dmx_tx` transmitter. Each frame it reads channel levels from a dual-bank channel RAM and presents them to the transmitter over its `avail`/`data`/`ack` handshake. A frame is the start code, flagged to force break/MAB, followed by NUM_CH channel bytes. Frame-to-frame spacing is held to a programmable minimum period. It sits between the host-written channel RAM and `dmx_tx`, sharing `clk`, `rst_n` and `baudEn`.

## Interface
- NUM_CH, 512, channels per frame (1..512)
- START_CODE, 8'h00, start code byte sent first in every frame
- clk  in  1  system clock
- rst_n  in  1  async, active-low system reset
- baudEn  in  1  16x baud enable; clocks the inter-frame timer
- enable  in  1  run frames; sampled only at frame boundaries
- period  in  20  minimum start-to-start frame interval, in baudEn ticks
- buf_sel  in  1  requested RAM bank; latched at frame start
- rd_en  out  1  RAM read strobe, one-cycle pulse
- rd_addr  out  10  {bank, channel index 0..NUM_CH-1}
- rd_data  in  8  RAM data, valid the cycle after rd_en
- tx_avail  out  1  to dmx_tx avail
- tx_data  out  9  to dmx_tx data; bit 8 = send break/MAB first
- tx_ack  in  1  from dmx_tx ack, one-cycle pulse
- frame_start  out  1  pulse: start code presented
- frame_done  out  1  pulse: last channel accepted
- busy  out  1  frame in progress (START through last ack)
- active_bank  out  1  bank latched for the current/last frame

## Operation
- States: IDLE, START, FETCH, CAPTURE, PRESENT, GAP.
- IDLE: `enable` = 1 -> START.
- START:
  - Latch `buf_sel` into `active_bank`.
  - Clear channel index and frame timer.
  - Drive `tx_data` = {1'b1, START_CODE} and `tx_avail` = 1; pulse `frame_start`.
  - Wait for `tx_ack`, then go to FETCH.
- FETCH: pulse `rd_en` with `rd_addr` = {active_bank, idx} -> CAPTURE.
- CAPTURE: load `tx_data` = {1'b0, rd_data} and set `tx_avail` = 1 -> PRESENT.
- PRESENT: hold `tx_avail` and `tx_data` stable until `tx_ack`. On ack:
  - idx = NUM_CH-1: pulse `frame_done` and go to GAP.
  - Otherwise: increment idx and go to FETCH.
- GAP:
  - `enable` = 0 -> IDLE.
  - `enable` = 1 and timer >= `period` -> START.
  - Otherwise remain in GAP.
- Frame timer:
  - 20 bits; increments on each `baudEn`; saturates at all-ones.
  - Cleared in START; counts through the whole frame and GAP.
- `period` = 0, or a frame that already ran longer than `period`: START follows GAP on the next cycle.
- `enable` falling mid-frame: the frame completes normally, then IDLE. `enable` rising in IDLE: START next cycle.
- `buf_sel` changes mid-frame have no effect until the next START; a frame never mixes banks.
- `tx_ack` while `tx_avail` = 0 is ignored.
- `busy` = 1 from START through the `frame_done` cycle, otherwise 0.

## Timing
- Reset values (async, immediate): all outputs 0, including `tx_avail`, `tx_data`, `rd_en`, `rd_addr`, `active_bank` and both pulses. State = IDLE, timer = 0.
- Reset mid-frame drops `tx_avail` immediately. After release the next frame begins again with the start code.
- `tx_avail` is registered:
  - It falls in the cycle after `tx_ack` is sampled.
  - It rises 3 cycles after the ack of the previous byte (FETCH, CAPTURE, PRESENT).
  - Both margins are well inside one 16-baudEn-tick window, so `dmx_tx` never double-accepts a byte.
- `frame_start` is coincident with the first cycle of START `tx_avail`. `frame_done` is coincident with the cycle the last `tx_ack` is sampled.
- RAM latency is exactly 1 cycle; no other pipelining.

## Test plan
- **Basic frame.** NUM_CH=4, bank0 = 11,22,33,44, period=0, `dmx_tx` attached. Required response:
  - `tx_data` accepted in order: 0x100, 0x011, 0x022, 0x033, 0x044.
  - One `frame_start` and one `frame_done` per frame; frames repeat back-to-back.
- **Slow ack.** Ack model delays `tx_ack` by 200 cycles -> `tx_avail` and `tx_data` stay stable throughout; exactly one accept per byte; `rd_en` count = 4 per frame.
- **Minimum period.** NUM_CH=4, period=5000, baudEn every 4 cycles -> `frame_start` pulses are exactly 5000 baudEn ticks (20000 cycles, ±1 cycle) apart.
- **Bank switch.** bank1 = AA,BB,CC,DD; toggle `buf_sel` to 1 during channel 2 -> the current frame finishes with 33,44 from bank0; the next frame sends 0x0AA..0x0DD and `active_bank` = 1.
- **Enable off.** Drop `enable` at channel 1 -> all 4 channels are still sent, then `busy` = 0, state IDLE, and no further `frame_start`. Re-assert -> `frame_start` on the next cycle.
- **Reset mid-frame.** Assert `rst_n` = 0 while `tx_avail` = 1 -> all outputs go to 0 in the same cycle; after release with `enable` = 1, the first accepted byte is 0x100.
